// File: rtl/pipe_field_gen.sv
// pipe_field_gen: NUM_PIPES scrolling pipes with speed ramp, LFSR gap positions and a score strobe.
// Optional feature macro GAP_SHRINK_EN: respawned gap height narrows with ramp level.
// Latency: outputs update one clk after a RUN frame_en; no backpressure, every frame strobe is consumed.
module pipe_field_gen #(
   parameter int NUM_PIPES   = 3,
   parameter int XW          = 12,
   parameter int PIPE_W      = 80,
   parameter int PIPE_DIST   = 400,
   parameter int START_X     = 400,
   parameter int BIRD_X      = 300,
   parameter int GAP_MIN_Y   = 200,
   parameter int GAP_RANGE   = 300,
   parameter int SPEED_INIT  = 3,
   parameter int SPEED_STEP  = 5,
   parameter int SPEED_MAX   = 12,
   parameter int RAMP_FRAMES = 180,
   parameter int GAP_H_INIT  = 220,
   parameter int GAP_H_STEP  = 10,
   parameter int GAP_H_MIN   = 140
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    game_active,
   input  logic                    pause,
   input  logic                    frame_en,
   input  logic                    seed_load,
   input  logic [15:0]             seed,
   output logic [NUM_PIPES*XW-1:0] pipe_x,
   output logic [NUM_PIPES*XW-1:0] pipe_gap_y,
   output logic [NUM_PIPES*8-1:0]  pipe_gap_h,
   output logic                    score_pulse,
   output logic [7:0]              speed_px,
   output logic [3:0]              level
);

   // Pipe x is two's complement so a pipe can slide partly off the left edge
   // before it respawns; SW adds headroom for the move/respawn arithmetic.
   localparam int SW = XW + 2;
   localparam int RW = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;
   localparam logic [15:0]          LFSR_INIT  = 16'hACE1;
   localparam logic [11:0]          SPEED_Q0   = 12'(SPEED_INIT * 16);
   localparam logic [12:0]          SPEED_QMAX = 13'(SPEED_MAX * 16);
   localparam logic signed [SW-1:0] PW_S       = SW'(PIPE_W);
   localparam logic signed [SW-1:0] DIST_S     = SW'(PIPE_DIST);
   localparam logic signed [SW-1:0] THR_S      = SW'(BIRD_X - PIPE_W);
   localparam logic [XW-1:0]        GAP_Y0     = XW'(GAP_MIN_Y + GAP_RANGE / 2);
   localparam logic [7:0]           GAP_H0     = 8'(GAP_H_INIT);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED} state_t;

   state_t state, state_nxt;
   logic   frame_go;

   logic signed [XW-1:0] x_q  [NUM_PIPES];
   logic [XW-1:0]        gy_q [NUM_PIPES];
   logic [7:0]           gh_q [NUM_PIPES];
   logic [11:0]          speed_q;
   logic [3:0]           frac_q;
   logic [RW-1:0]        ramp_q;
   logic [3:0]           level_q;
   logic                 score_q;
   logic [15:0]          lfsr_q;
   logic                 lfsr_fb;

   logic [12:0]          acc;
   logic signed [SW-1:0] step_s;
   logic signed [SW-1:0] old_x, moved_x, prev_x;
   logic signed [SW-1:0] x_nxt  [NUM_PIPES];
   logic [XW-1:0]        gy_nxt [NUM_PIPES];
   logic [7:0]           gh_nxt [NUM_PIPES];
   logic                 cross_any;
   logic [7:0]           gh_resp;

   logic [RW-1:0]        ramp_nxt;
   logic [11:0]          speed_nxt;
   logic [12:0]          speed_sum;
   logic [3:0]           level_nxt;

   function automatic logic signed [SW-1:0] sext(input logic signed [XW-1:0] v);
      return $signed({{(SW-XW){v[XW-1]}}, v});
   endfunction

   function automatic logic signed [XW-1:0] start_x(input int idx);
      return XW'(START_X + idx * PIPE_DIST);
   endfunction

   // Gap centre for pipe idx: LFSR rotated left by 5*idx, folded into the gap span.
   function automatic logic [XW-1:0] gap_pick(input logic [15:0] r, input int idx);
      logic [15:0] rot;
      int          sh;
      sh  = (5 * idx) % 16;
      rot = (r << sh) | (r >> ((16 - sh) % 16));
      return XW'(32'(GAP_MIN_Y) + ({16'b0, rot} % 32'(GAP_RANGE)));
   endfunction

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next state and frame-commit strobe; game_active low wins over everything.
   always_comb begin
      state_nxt = state;
      frame_go  = 1'b0;
      if (!game_active) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE:   state_nxt = S_RUN;
            S_RUN:    if (pause) state_nxt = S_PAUSED;
            S_PAUSED: if (!pause) state_nxt = S_RUN;
            default:  state_nxt = S_IDLE;
         endcase
         frame_go = (state == S_RUN) && !pause && frame_en;
      end
   end

`ifdef GAP_SHRINK_EN
   int gh_calc;
   // Respawn gap height narrows by one step per level down to the floor.
   always_comb begin
      gh_calc = GAP_H_INIT - int'(level_q) * GAP_H_STEP;
      if (gh_calc < GAP_H_MIN) gh_calc = GAP_H_MIN;
      gh_resp = 8'(gh_calc);
   end
`else
   assign gh_resp = GAP_H0;
`endif

   // Sub-pixel step and per-pipe move/respawn, chained in index order so each
   // respawn lands PIPE_DIST behind its predecessor's post-move position.
   always_comb begin
      acc       = 13'(frac_q) + 13'(speed_q);
      step_s    = SW'(acc[12:4]);
      cross_any = 1'b0;
      prev_x    = sext(x_q[NUM_PIPES-1]) - step_s;
      old_x     = '0;
      moved_x   = '0;
      for (int i = 0; i < NUM_PIPES; i++) begin
         old_x     = sext(x_q[i]);
         moved_x   = old_x - step_s;
         gy_nxt[i] = gy_q[i];
         gh_nxt[i] = gh_q[i];
         if (old_x + PW_S <= step_s) begin
            x_nxt[i]  = prev_x + DIST_S;
            gy_nxt[i] = gap_pick(lfsr_q, i);
            gh_nxt[i] = gh_resp;
         end else begin
            x_nxt[i] = moved_x;
            if ((old_x >= THR_S) && (moved_x < THR_S)) cross_any = 1'b1;
         end
         prev_x = x_nxt[i];
      end
   end

   // Ramp: every RAMP_FRAMES run frames bump speed and level, both saturating.
   always_comb begin
      ramp_nxt  = ramp_q + 1'b1;
      speed_nxt = speed_q;
      level_nxt = level_q;
      speed_sum = 13'(speed_q) + 13'(SPEED_STEP);
      if (ramp_q == RW'(RAMP_FRAMES - 1)) begin
         ramp_nxt  = '0;
         speed_nxt = (speed_sum > SPEED_QMAX) ? SPEED_QMAX[11:0] : speed_sum[11:0];
         if (level_q != 4'hF) level_nxt = level_q + 4'd1;
      end
   end

   // Field state: cleared by reset or leaving the game, committed on run frames.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_PIPES; i++) begin
            x_q[i]  <= start_x(i);
            gy_q[i] <= GAP_Y0;
            gh_q[i] <= GAP_H0;
         end
         speed_q <= SPEED_Q0;
         frac_q  <= '0;
         ramp_q  <= '0;
         level_q <= '0;
         score_q <= 1'b0;
      end else if (!game_active) begin
         for (int i = 0; i < NUM_PIPES; i++) begin
            x_q[i]  <= start_x(i);
            gy_q[i] <= GAP_Y0;
            gh_q[i] <= GAP_H0;
         end
         speed_q <= SPEED_Q0;
         frac_q  <= '0;
         ramp_q  <= '0;
         level_q <= '0;
         score_q <= 1'b0;
      end else begin
         score_q <= 1'b0;
         if (frame_go) begin
            for (int i = 0; i < NUM_PIPES; i++) begin
               x_q[i]  <= XW'(x_nxt[i]);
               gy_q[i] <= gy_nxt[i];
               gh_q[i] <= gh_nxt[i];
            end
            frac_q  <= acc[3:0];
            ramp_q  <= ramp_nxt;
            speed_q <= speed_nxt;
            level_q <= level_nxt;
            score_q <= cross_any;
         end
      end
   end

   assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

   // LFSR runs on every frame strobe regardless of state; a zero seed would lock it up.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         lfsr_q <= LFSR_INIT;
      else if (seed_load) lfsr_q <= (seed == 16'h0000) ? LFSR_INIT : seed;
      else if (frame_en)  lfsr_q <= {lfsr_q[14:0], lfsr_fb};
   end

   // Pack per-pipe registers onto the flat output buses.
   always_comb begin
      pipe_x     = '0;
      pipe_gap_y = '0;
      pipe_gap_h = '0;
      for (int i = 0; i < NUM_PIPES; i++) begin
         pipe_x[i*XW +: XW]     = x_q[i];
         pipe_gap_y[i*XW +: XW] = gy_q[i];
         pipe_gap_h[i*8 +: 8]   = gh_q[i];
      end
   end

   assign score_pulse = score_q;
   assign speed_px    = speed_q[11:4];
   assign level       = level_q;

endmodule

// File: tb/tb_pipe_field_gen.sv
// Directed bench for pipe_field_gen at default parameters (3 pipes, 12-bit x).
// Frames are issued back to back; outputs are sampled on the falling edge.
// Gap-height expectations follow GAP_SHRINK_EN when the bench is built with it.
module tb_pipe_field_gen;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        game_active = 1'b0;
   logic        pause = 1'b0;
   logic        frame_en = 1'b0;
   logic        seed_load = 1'b0;
   logic [15:0] seed = 16'h0000;
   logic [35:0] pipe_x;
   logic [35:0] pipe_gap_y;
   logic [23:0] pipe_gap_h;
   logic        score_pulse;
   logic [7:0]  speed_px;
   logic [3:0]  level;

   int tests = 0;
   int fails = 0;

`ifdef GAP_SHRINK_EN
   localparam int GH_LATE = 140;
`else
   localparam int GH_LATE = 220;
`endif

   pipe_field_gen dut (
      .clk(clk), .rst_n(rst_n), .game_active(game_active), .pause(pause),
      .frame_en(frame_en), .seed_load(seed_load), .seed(seed),
      .pipe_x(pipe_x), .pipe_gap_y(pipe_gap_y), .pipe_gap_h(pipe_gap_h),
      .score_pulse(score_pulse), .speed_px(speed_px), .level(level)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog expired got running want finished");
      $fatal(1, "watchdog");
   end

   function automatic int px(input int i);
      logic signed [11:0] v;
      v = pipe_x[i*12 +: 12];
      return int'(v);
   endfunction

   function automatic int gy(input int i);
      return int'(pipe_gap_y[i*12 +: 12]);
   endfunction

   function automatic int gh(input int i);
      return int'(pipe_gap_h[i*8 +: 8]);
   endfunction

   // One frame strobe; returns on the falling edge right after the update.
   task automatic do_frame();
      frame_en = 1'b1;
      @(negedge clk);
      frame_en = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      tests++; if (px(0) !== 400) begin fails++; $display("FAIL rst_x0 got %0d want 400", px(0)); end
      tests++; if (px(1) !== 800) begin fails++; $display("FAIL rst_x1 got %0d want 800", px(1)); end
      tests++; if (px(2) !== 1200) begin fails++; $display("FAIL rst_x2 got %0d want 1200", px(2)); end
      tests++; if (gy(0) !== 350) begin fails++; $display("FAIL rst_gy0 got %0d want 350", gy(0)); end
      tests++; if (gh(2) !== 220) begin fails++; $display("FAIL rst_gh2 got %0d want 220", gh(2)); end
      tests++; if (speed_px !== 8'd3) begin fails++; $display("FAIL rst_speed got %0d want 3", speed_px); end
      tests++; if (level !== 4'd0) begin fails++; $display("FAIL rst_level got %0d want 0", level); end
      tests++; if (score_pulse !== 1'b0) begin fails++; $display("FAIL rst_score got %0b want 0", score_pulse); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_run_basic();
      int seen;
      seen = 0;
      game_active = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 10; k++) begin
         do_frame();
         if (score_pulse === 1'b1) seen++;
      end
      tests++; if (px(0) !== 370) begin fails++; $display("FAIL run_x0 got %0d want 370", px(0)); end
      tests++; if (px(1) !== 770) begin fails++; $display("FAIL run_x1 got %0d want 770", px(1)); end
      tests++; if (px(2) !== 1170) begin fails++; $display("FAIL run_x2 got %0d want 1170", px(2)); end
      tests++; if (speed_px !== 8'd3) begin fails++; $display("FAIL run_speed got %0d want 3", speed_px); end
      tests++; if (seen !== 0) begin fails++; $display("FAIL run_no_score got %0d pulses want 0", seen); end
   endtask

   task automatic test_ramp();
      for (int k = 0; k < 170; k++) do_frame();
      // pipe0 respawned on frame 160 at (723-3)+400 = 1120, then 20 more frames
      tests++; if (px(0) !== 1060) begin fails++; $display("FAIL ramp_x0 got %0d want 1060", px(0)); end
      tests++; if (px(1) !== 260) begin fails++; $display("FAIL ramp_x1 got %0d want 260", px(1)); end
      tests++; if (px(2) !== 660) begin fails++; $display("FAIL ramp_x2 got %0d want 660", px(2)); end
      tests++; if (level !== 4'd1) begin fails++; $display("FAIL ramp_level got %0d want 1", level); end
      tests++; if (speed_px !== 8'd3) begin fails++; $display("FAIL ramp_speed got %0d want 3", speed_px); end
      do_frame();
      tests++; if (px(1) !== 257) begin fails++; $display("FAIL frac_first got %0d want 257", px(1)); end
      for (int k = 0; k < 15; k++) do_frame();
      // 16 frames at 53/16 px advance exactly 53 px
      tests++; if (px(1) !== 207) begin fails++; $display("FAIL frac_x1 got %0d want 207", px(1)); end
      tests++; if (px(0) !== 1007) begin fails++; $display("FAIL frac_x0 got %0d want 1007", px(0)); end
      tests++; if (px(2) !== 607) begin fails++; $display("FAIL frac_x2 got %0d want 607", px(2)); end
   endtask

   task automatic test_score();
      game_active = 1'b0;
      @(negedge clk);
      tests++; if (px(0) !== 400) begin fails++; $display("FAIL idle_x0 got %0d want 400", px(0)); end
      tests++; if (level !== 4'd0) begin fails++; $display("FAIL idle_level got %0d want 0", level); end
      tests++; if (speed_px !== 8'd3) begin fails++; $display("FAIL idle_speed got %0d want 3", speed_px); end
      game_active = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 59; k++) do_frame();
      tests++; if (px(0) !== 223) begin fails++; $display("FAIL sc_x0_223 got %0d want 223", px(0)); end
      do_frame();
      tests++; if (px(0) !== 220) begin fails++; $display("FAIL sc_x0_220 got %0d want 220", px(0)); end
      tests++; if (score_pulse !== 1'b0) begin fails++; $display("FAIL sc_at_thr got %0b want 0", score_pulse); end
      do_frame();
      tests++; if (px(0) !== 217) begin fails++; $display("FAIL sc_x0_217 got %0d want 217", px(0)); end
      tests++; if (score_pulse !== 1'b1) begin fails++; $display("FAIL sc_pulse got %0b want 1", score_pulse); end
      @(negedge clk);
      tests++; if (score_pulse !== 1'b0) begin fails++; $display("FAIL sc_one_clk got %0b want 0", score_pulse); end
      do_frame();
      tests++; if (px(0) !== 214) begin fails++; $display("FAIL sc_x0_214 got %0d want 214", px(0)); end
      tests++; if (score_pulse !== 1'b0) begin fails++; $display("FAIL sc_after got %0b want 0", score_pulse); end
   endtask

   task automatic test_respawn();
      for (int k = 0; k < 97; k++) do_frame();
      tests++; if (px(0) !== -77) begin fails++; $display("FAIL resp_pre got %0d want -77", px(0)); end
      seed = 16'h1234;
      seed_load = 1'b1;
      @(negedge clk);
      seed_load = 1'b0;
      do_frame();
      tests++; if (px(0) !== 1120) begin fails++; $display("FAIL resp_x0 got %0d want 1120", px(0)); end
      tests++; if (px(1) !== 320) begin fails++; $display("FAIL resp_x1 got %0d want 320", px(1)); end
      tests++; if (px(2) !== 720) begin fails++; $display("FAIL resp_x2 got %0d want 720", px(2)); end
      // 0x1234 = 4660, 4660 % 300 = 160
      tests++; if (gy(0) !== 360) begin fails++; $display("FAIL resp_gy0 got %0d want 360", gy(0)); end
      tests++; if (gy(0) < 200 || gy(0) > 499) begin fails++; $display("FAIL resp_gy_range got %0d want 200..499", gy(0)); end
      tests++; if (gy(1) !== 350) begin fails++; $display("FAIL resp_gy1 got %0d want 350", gy(1)); end
      tests++; if (gh(0) !== 220) begin fails++; $display("FAIL resp_gh0 got %0d want 220", gh(0)); end
   endtask

   task automatic test_pause();
      int seen;
      seen = 0;
      pause = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 20; k++) begin
         do_frame();
         if (score_pulse !== 1'b0) seen++;
      end
      tests++; if (px(0) !== 1120) begin fails++; $display("FAIL pz_x0 got %0d want 1120", px(0)); end
      tests++; if (px(1) !== 320) begin fails++; $display("FAIL pz_x1 got %0d want 320", px(1)); end
      tests++; if (level !== 4'd0) begin fails++; $display("FAIL pz_level got %0d want 0", level); end
      tests++; if (seen !== 0) begin fails++; $display("FAIL pz_score got %0d pulses want 0", seen); end
      pause = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 19; k++) do_frame();
      tests++; if (px(0) !== 1063) begin fails++; $display("FAIL pz_resume_x0 got %0d want 1063", px(0)); end
      tests++; if (level !== 4'd0) begin fails++; $display("FAIL pz_timer_held got %0d want 0", level); end
      do_frame();
      tests++; if (level !== 4'd1) begin fails++; $display("FAIL pz_wrap got %0d want 1", level); end
      tests++; if (px(0) !== 1060) begin fails++; $display("FAIL pz_x0_end got %0d want 1060", px(0)); end
      pause = 1'b1;
      @(negedge clk);
      game_active = 1'b0;
      pause = 1'b0;
      @(negedge clk);
      tests++; if (px(0) !== 400) begin fails++; $display("FAIL drop_x0 got %0d want 400", px(0)); end
      tests++; if (px(2) !== 1200) begin fails++; $display("FAIL drop_x2 got %0d want 1200", px(2)); end
      tests++; if (gy(0) !== 350) begin fails++; $display("FAIL drop_gy0 got %0d want 350", gy(0)); end
      tests++; if (level !== 4'd0) begin fails++; $display("FAIL drop_level got %0d want 0", level); end
      tests++; if (speed_px !== 8'd3) begin fails++; $display("FAIL drop_speed got %0d want 3", speed_px); end
   endtask

   task automatic test_shrink_and_sat();
      game_active = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 1620; k++) do_frame();
      tests++; if (level !== 4'd9) begin fails++; $display("FAIL lv9_level got %0d want 9", level); end
      tests++; if (speed_px !== 8'd5) begin fails++; $display("FAIL lv9_speed got %0d want 5", speed_px); end
      for (int k = 0; k < 300; k++) do_frame();
      tests++; if (level !== 4'd10) begin fails++; $display("FAIL lv10_level got %0d want 10", level); end
      tests++; if (speed_px !== 8'd6) begin fails++; $display("FAIL lv10_speed got %0d want 6", speed_px); end
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (gh(i) !== GH_LATE) begin fails++; $display("FAIL late_gh%0d got %0d want %0d", i, gh(i), GH_LATE); end
      end
      for (int k = 0; k < 3120; k++) do_frame();
      tests++; if (level !== 4'd15) begin fails++; $display("FAIL lv_sat got %0d want 15", level); end
      tests++; if (speed_px !== 8'd11) begin fails++; $display("FAIL speed_188 got %0d want 11", speed_px); end
      for (int k = 0; k < 180; k++) do_frame();
      tests++; if (speed_px !== 8'd12) begin fails++; $display("FAIL speed_max got %0d want 12", speed_px); end
      tests++; if (level !== 4'd15) begin fails++; $display("FAIL lv_hold got %0d want 15", level); end
   endtask

   initial begin
      test_reset();
      test_run_basic();
      test_ramp();
      test_score();
      test_respawn();
      test_pause();
      test_shrink_and_sat();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
